regfile_writer: RTL and testbench

REGFILE_WRITER -- requirements
Module: regfile_writer

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_write_fifo.sv | 67 ++++++
 rtl/regfile_writer.sv | 162 ++++++++++++++++
 tb/tb_regfile_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write arbiter:
//   REG_ADDR_W / REG_DATA_W / REG_COUNT : register-file geometry
//   wr_src_e                            : which requester won the write port
//   wr_entry_t                          : one buffered multi-cycle-unit write
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 32;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_MCU  = 2'd2
   } wr_src_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] address;
      logic [REG_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/regfile_write_fifo.sv
// ---------------------------------------------------------------------------
// regfile_write_fifo
// Buffer for multi-cycle-unit register writes. Storage is plain synchronous
// memory (no reset); only the pointers are reset, asynchronously.
// Ports:
//   i_clock, i_reset            : clock, asynchronous active-high reset
//   i_push, i_push_addr/_data   : write one entry (ignored when full)
//   i_pop                       : drop the head entry (ignored when empty)
//   o_head_addr, o_head_data    : current head entry
//   o_full, o_empty             : occupancy flags, from registered pointers
// ---------------------------------------------------------------------------
module regfile_write_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_push,
   input  logic [REG_ADDR_W-1:0] i_push_addr,
   input  logic [REG_DATA_W-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [REG_ADDR_W-1:0] o_head_addr,
   output logic [REG_DATA_W-1:0] o_head_data,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wr_entry_t   r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push_ok;
   logic        w_pop_ok;
   wr_entry_t   w_push_entry;
   wr_entry_t   w_head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   assign w_push_entry.address = i_push_addr;
   assign w_push_entry.data    = i_push_data;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
   end

   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign o_head_addr = w_head.address;
   assign o_head_data = w_head.data;

endmodule

// File: rtl/regfile_writer.sv
// ---------------------------------------------------------------------------
// regfile_writer
// Arbitrates the single register-file write port between the pipeline
// writeback (priority) and buffered multi-cycle-unit (MCU) results. A buffered
// head that keeps losing is forced through after STARVE_LIMIT losses, stalling
// the pipe for that cycle. The write port is registered (one-cycle latency).
// Optional macro REGFILE_WRITER_SCOREBOARD_EN compiles in the per-register
// pending-write scoreboard on busy; otherwise busy is 0 and issue_* is unused.
// Ports:
//   clock, reset                          : clock, async active-high reset
//   pipe_valid/_address/_data, pipe_stall : pipeline writeback request
//   mcu_valid/_ready/_address/_data       : MCU result handshake
//   issue_valid, issue_address            : MCU op issued to a register
//   write_enable/_address/_data           : registered regfile write port
//   busy                                  : pending MCU write per register
// ---------------------------------------------------------------------------
module regfile_writer
   import regfile_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pipe_valid,
   input  logic [REG_ADDR_W-1:0] pipe_address,
   input  logic [REG_DATA_W-1:0] pipe_data,
   output logic                  pipe_stall,
   input  logic                  mcu_valid,
   output logic                  mcu_ready,
   input  logic [REG_ADDR_W-1:0] mcu_address,
   input  logic [REG_DATA_W-1:0] mcu_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_address,
   output logic                  write_enable,
   output logic [REG_ADDR_W-1:0] write_address,
   output logic [REG_DATA_W-1:0] write_data,
   output logic [REG_COUNT-1:0]  busy
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_pipe_req;
   logic                  w_force;
   logic [REG_ADDR_W-1:0] w_head_addr;
   logic [REG_DATA_W-1:0] w_head_data;
   wr_src_e               w_src;
   logic [REG_ADDR_W-1:0] w_win_addr;
   logic [REG_DATA_W-1:0] w_win_data;

   logic [SW-1:0]         r_starve;
   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic [REG_DATA_W-1:0] r_wdata;

   // No same-cycle bypass: a pop while full frees the slot next cycle only.
   assign mcu_ready  = !w_full;
   assign w_push     = mcu_valid && !w_full;

   // Writes to r0 are discarded, so a pipe write to r0 is not a request.
   assign w_pipe_req = pipe_valid && (pipe_address != '0);
   assign w_force    = !w_empty && (r_starve == STARVE_MAX);
   assign pipe_stall = w_force;

   always_comb begin
      w_src      = SRC_NONE;
      w_win_addr = '0;
      w_win_data = '0;
      if (!w_empty && (w_force || !w_pipe_req)) begin
         w_src      = SRC_MCU;
         w_win_addr = w_head_addr;
         w_win_data = w_head_data;
      end else if (w_pipe_req) begin
         w_src      = SRC_PIPE;
         w_win_addr = pipe_address;
         w_win_data = pipe_data;
      end
   end

   assign w_pop = (w_src == SRC_MCU);

   regfile_write_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_push      (w_push),
      .i_push_addr (mcu_address),
      .i_push_data (mcu_data),
      .i_pop       (w_pop),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // Counts losses of the current head; a pop always restarts the count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_starve <= '0;
      end else if (w_pop) begin
         r_starve <= '0;
      end else if (!w_empty && w_pipe_req) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   // An MCU entry for r0 still pops, but never raises write_enable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we    <= (w_src != SRC_NONE) && (w_win_addr != '0);
         r_waddr <= w_win_addr;
         r_wdata <= w_win_data;
      end
   end

   assign write_enable  = r_we;
   assign write_address = r_waddr;
   assign write_data    = r_wdata;

`ifdef REGFILE_WRITER_SCOREBOARD_EN
   logic                 r_mcu_wr;
   logic [REG_COUNT-1:0] r_busy;
   logic [REG_COUNT-1:0] w_set;
   logic [REG_COUNT-1:0] w_clr;

   // Marks the registered write as MCU-sourced so busy clears as it leaves.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_mcu_wr <= 1'b0;
      else       r_mcu_wr <= (w_src == SRC_MCU) && (w_win_addr != '0);
   end

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (issue_valid && (issue_address != '0)) w_set[issue_address] = 1'b1;
      if (r_mcu_wr)                             w_clr[r_waddr]       = 1'b1;
   end

   // Set is applied after clear so a same-cycle re-issue keeps the bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_busy <= '0;
      else       r_busy <= (r_busy & ~w_clr) | w_set;
   end

   assign busy = r_busy;
`else
   logic w_unused_issue;
   assign w_unused_issue = ^{issue_valid, issue_address};
   assign busy           = '0;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;
   import regfile_pkg::*;

   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        pipe_valid = 1'b0;
   logic [4:0]  pipe_address = '0;
   logic [31:0] pipe_data = '0;
   logic        pipe_stall;
   logic        mcu_valid = 1'b0;
   logic        mcu_ready;
   logic [4:0]  mcu_address = '0;
   logic [31:0] mcu_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_address = '0;
   logic        write_enable;
   logic [4:0]  write_address;
   logic [31:0] write_data;
   logic [31:0] busy;

   regfile_writer #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .pipe_valid    (pipe_valid),
      .pipe_address  (pipe_address),
      .pipe_data     (pipe_data),
      .pipe_stall    (pipe_stall),
      .mcu_valid     (mcu_valid),
      .mcu_ready     (mcu_ready),
      .mcu_address   (mcu_address),
      .mcu_data      (mcu_data),
      .issue_valid   (issue_valid),
      .issue_address (issue_address),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_data    (write_data),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   // Reference model: a queue of buffered results plus a loss counter.
   typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
   typedef struct { logic [4:0] a; logic [31:0] d; int due; } wexp_t;
   typedef struct { logic [31:0] b; int due; } bexp_t;

   ent_t        mq[$];
   wexp_t       wq[$];
   bexp_t       bq[$];
   int          starve_m  = 0;
   logic [31:0] busy_m    = '0;
   int          clear_now = -1;
   bit          in_reset  = 1'b1;

   task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] ia, output logic acc);
      bit    pipe_req, force_m, ready_m;
      int    clear_next;
      ent_t  h;
      wexp_t w;
      bexp_t b;
      @(negedge clock);
      pipe_valid = pv; pipe_address = pa; pipe_data = pd;
      mcu_valid = mv; mcu_address = ma; mcu_data = md;
      issue_valid = iv; issue_address = ia;
      #1;
      ready_m  = (mq.size() < FIFO_DEPTH);
      pipe_req = pv && (pa != 5'd0);
      force_m  = (mq.size() != 0) && (starve_m == STARVE_LIMIT);
      chk("mcu_ready", {31'b0, mcu_ready}, {31'b0, ready_m});
      chk("pipe_stall", {31'b0, pipe_stall}, {31'b0, force_m});
      clear_next = -1;
      if (mq.size() != 0 && (force_m || !pipe_req)) begin
         h = mq.pop_front();
         starve_m = 0;
         if (h.a != 5'd0) begin
            w.a = h.a; w.d = h.d; w.due = cyc + 1;
            wq.push_back(w);
            clear_next = int'(h.a);
         end
      end else if (pipe_req) begin
         w.a = pa; w.d = pd; w.due = cyc + 1;
         wq.push_back(w);
         if (mq.size() != 0) starve_m++;
      end
      acc = mv && ready_m;
      if (acc) begin
         h.a = ma; h.d = md;
         mq.push_back(h);
      end
      if (clear_now > 0) busy_m[clear_now] = 1'b0;
      if (iv && ia != 5'd0) busy_m[ia] = 1'b1;
`ifdef REGFILE_WRITER_SCOREBOARD_EN
      b.b = busy_m;
`else
      b.b = '0;
`endif
      b.due = cyc + 1;
      bq.push_back(b);
      clear_now = clear_next;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
   endtask

   task automatic do_reset();
      @(negedge clock);
      pipe_valid = 0; mcu_valid = 0; issue_valid = 0;
      #1;
      in_reset = 1'b1;
      reset = 1'b1;
      #1;
      chk("rst_write_enable", {31'b0, write_enable}, 0);
      chk("rst_write_address", {27'b0, write_address}, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mcu_ready", {31'b0, mcu_ready}, 1);
      chk("rst_pipe_stall", {31'b0, pipe_stall}, 0);
      mq.delete(); wq.delete(); bq.delete();
      starve_m = 0; busy_m = '0; clear_now = -1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("release_write_enable", {31'b0, write_enable}, 0);
      in_reset = 1'b0;
   endtask

   // Monitor: compares the registered write port and busy against expectations.
   wexp_t mon_w;
   bexp_t mon_b;
   bit    exp_we;
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (!in_reset) begin
            exp_we = (wq.size() != 0) && (wq[0].due == cyc);
            chk("write_enable", {31'b0, write_enable}, {31'b0, exp_we});
            if (exp_we) begin
               mon_w = wq.pop_front();
               if (write_enable) begin
                  chk("write_address", {27'b0, write_address}, {27'b0, mon_w.a});
                  chk("write_data", write_data, mon_w.d);
               end
            end
            if (bq.size() != 0 && bq[0].due == cyc) begin
               mon_b = bq.pop_front();
               chk("busy", busy, mon_b.b);
            end
         end
      end
   end

   initial begin
      logic acc;
      int   n;
      #1;
      do_reset();

      // Pipe write lands one cycle later.
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
      idle(2);

      // r0 pipe write is no request; the buffered write to 7 goes instead.
      step(1, 3, 32'h33, 1, 7, 32'h7777, 0, 0, acc);
      step(1, 0, 32'hBAD0, 0, 0, 0, 0, 0, acc);
      idle(3);

      // Scoreboard bit 9 from issue to MCU write-out.
      step(0, 0, 0, 0, 0, 0, 1, 9, acc);
      idle(1);
      step(0, 0, 0, 1, 9, 32'h1234, 0, 0, acc);
      idle(4);

      // Starvation: pipe every cycle, one buffered entry forced through.
      step(1, 1, 32'h100, 1, 17, 32'hA5A5, 0, 0, acc);
      for (int i = 0; i < STARVE_LIMIT + 3; i++)
         step(1, 1, 32'h101 + i, 0, 0, 0, 0, 0, acc);
      idle(3);

      // Back-to-back MCU results against a continuously writing pipe.
      for (int r = 0; r < 3; r++) begin
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 20) begin
            step(1, 2, 32'h200 + n, 1, 5'(20 + r), 32'hC000 + r, 0, 0, acc);
            n++;
         end
         if (!acc) chk("mcu_accept_timeout", {31'b0, acc}, 1);
      end
      for (int i = 0; i < 12; i++) step(1, 2, 32'h300 + i, 0, 0, 0, 0, 0, acc);
      idle(4);

      // Reset with a full buffer and busy bits 9 and 10 pending.
      step(0, 0, 0, 0, 0, 0, 1, 9, acc);
      step(0, 0, 0, 0, 0, 0, 1, 10, acc);
      step(1, 3, 32'h3, 1, 9, 32'h9999, 0, 0, acc);
      step(1, 4, 32'h4, 1, 10, 32'hAAAA, 0, 0, acc);
      step(1, 4, 32'h5, 1, 11, 32'hBBBB, 0, 0, acc);
      do_reset();
      idle(4);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              32'($urandom),
              logic'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              32'($urandom),
              logic'($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 31)),
              acc);
      end
      idle(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
